// File: rtl/lsu_spram.sv
// Load/store unit in front of a single-port SRAM: decodes core requests into word
// address, lane-replicated write data and byte enables, then extends the returned load data.
module lsu_spram #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_ben,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, MEM, LWAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic        we_q;

    logic [31:0] off;
    logic        accept;
    logic        dec_err;
    logic [31:0] st_wdata;
    logic [3:0]  st_ben;
    logic [31:0] sh;
    logic [31:0] ld_data;

    assign off       = req_addr - BASE_ADDR;
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_err = (off[31:16] != 16'd0);
        case (req_funct3)
            3'b000, 3'b100: ;
            3'b001, 3'b101: if (req_addr[0]) dec_err = 1'b1;
            3'b010:         if (req_addr[1:0] != 2'b00) dec_err = 1'b1;
            default:        dec_err = 1'b1;
        endcase
        if (req_we && req_funct3[2]) dec_err = 1'b1;
    end

    // Sub-word stores replicate the data on every lane; byte enables pick the target lane.
    always_comb begin
        st_wdata = req_wdata;
        st_ben   = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                st_wdata = {4{req_wdata[7:0]}};
                st_ben   = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{req_wdata[15:0]}};
                st_ben   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        sh      = mem_rdata >> {lane_q, 3'b000};
        ld_data = mem_rdata;
        case (funct3_q)
            3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld_data = {24'd0, sh[7:0]};
            3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld_data = {16'd0, sh[15:0]};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = dec_err ? RESP : MEM;
            MEM:     state_nxt = we_q ? RESP : LWAIT;
            LWAIT:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            funct3_q  <= 3'd0;
            lane_q    <= 2'd0;
            we_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_error <= 1'b0;
            mem_addr  <= 14'd0;
            mem_wdata <= 32'd0;
            mem_wen   <= 1'b0;
            mem_ben   <= 4'd0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    funct3_q <= req_funct3;
                    lane_q   <= req_addr[1:0];
                    we_q     <= req_we;
                    if (dec_err) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_rdata <= 32'd0;
                    end else begin
                        mem_addr <= off[15:2];
                        mem_wen  <= req_we;
                        mem_ben  <= req_we ? st_ben : 4'd0;
                        if (req_we) mem_wdata <= st_wdata;
                    end
                end
                MEM: begin
                    // The SRAM samples on this edge; dropping the strobe keeps each write one cycle wide.
                    mem_wen <= 1'b0;
                    mem_ben <= 4'd0;
                    if (we_q) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= 32'd0;
                    end
                end
                LWAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b0;
                    rsp_rdata <= ld_data;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_spram.sv
// Directed bench for lsu_spram: stores, sign/zero-extended loads, error decode,
// response backpressure and reset during a store.
module tb_lsu_spram;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [3:0]  mem_ben;

    int tests = 0;
    int fails = 0;

    lsu_spram #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ben(mem_ben), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request on a falling edge and withdraws it just after the accepting rising edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check("req_ready_before_accept", req_ready, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Load flow: MEM view, LWAIT view, then response on the third cycle.
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [13:0] exp_addr, input logic [31:0] exp_data);
        mem_rdata = rdata;
        issue(1'b0, f3, addr, 32'h0);
        @(negedge clk);
        check({tag, "_mem_addr"}, mem_addr, exp_addr);
        check({tag, "_mem_wen"}, mem_wen, 32'd0);
        check({tag, "_ben"}, mem_ben, 32'd0);
        @(negedge clk);
        check({tag, "_valid_early"}, rsp_valid, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, exp_data);
        check({tag, "_error"}, rsp_error, 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, rsp_valid, 32'd0);
    endtask

    task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] addr);
        issue(we, f3, addr, 32'hFFFF_FFFF);
        @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 32'd1);
        check({tag, "_error"}, rsp_error, 32'd1);
        check({tag, "_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_wen"}, mem_wen, 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, req_ready, 32'd1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1; mem_rdata = 32'd0;
        #2;
        check("rst_req_ready", req_ready, 32'd0);
        check("rst_rsp_valid", rsp_valid, 32'd0);
        check("rst_mem_wen", mem_wen, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // SW BASE+0x10
        issue(1'b1, 3'b010, BASE + 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        check("sw_mem_addr", mem_addr, 32'd4);
        check("sw_wen", mem_wen, 32'd1);
        check("sw_ben", mem_ben, 32'hF);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_req_ready_busy", req_ready, 32'd0);
        check("sw_valid_early", rsp_valid, 32'd0);
        @(negedge clk);
        check("sw_wen_pulse", mem_wen, 32'd0);
        check("sw_valid", rsp_valid, 32'd1);
        check("sw_error", rsp_error, 32'd0);
        check("sw_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        check("sw_idle", rsp_valid, 32'd0);

        // SB BASE+0x13
        issue(1'b1, 3'b000, BASE + 32'h13, 32'h0000_00A5);
        @(negedge clk);
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_ben", mem_ben, 32'b1000);
        check("sb_mem_addr", mem_addr, 32'd4);
        @(negedge clk);
        check("sb_valid", rsp_valid, 32'd1);
        @(negedge clk);

        // SH BASE+0x6 uses the upper half lanes
        issue(1'b1, 3'b001, BASE + 32'h6, 32'h1234_BEEF);
        @(negedge clk);
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_ben", mem_ben, 32'b1100);
        @(negedge clk);
        @(negedge clk);

        load("lb",  3'b000, BASE + 32'h13, 32'hA5EE_EEEE, 14'd4, 32'hFFFF_FFA5);
        load("lbu", 3'b100, BASE + 32'h13, 32'hA5EE_EEEE, 14'd4, 32'h0000_00A5);
        load("lh",  3'b001, BASE + 32'h2,  32'h8001_1234, 14'd0, 32'hFFFF_8001);
        load("lhu", 3'b101, BASE + 32'h2,  32'h8001_1234, 14'd0, 32'h0000_8001);
        load("lb0", 3'b000, BASE + 32'h1,  32'h0000_7F80, 14'd0, 32'h0000_007F);
        load("lw_top", 3'b010, BASE + 32'hFFFC, 32'hCAFE_F00D, 14'd16383, 32'hCAFE_F00D);

        bad("lw_mis",  1'b0, 3'b010, BASE + 32'h2);
        bad("sh_mis",  1'b1, 3'b001, BASE + 32'h1);
        bad("lw_oor",  1'b0, 3'b010, BASE + 32'h1_0000);
        bad("f3_011",  1'b0, 3'b011, BASE);
        bad("below",   1'b0, 3'b010, BASE - 32'h4);
        bad("sbu",     1'b1, 3'b100, BASE);

        // Backpressure on a load response
        rsp_ready = 1'b0;
        mem_rdata = 32'h1234_5678;
        issue(1'b0, 3'b010, BASE + 32'h4, 32'h0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mem_rdata = 32'h0BAD_0000 + i;
            req_valid = 1'b1;
            check("bp_valid", rsp_valid, 32'd1);
            check("bp_rdata", rsp_rdata, 32'h1234_5678);
            check("bp_req_ready", req_ready, 32'd0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 32'd0);
        check("bp_release_ready", req_ready, 32'd1);

        // Reset while a store is in MEM
        issue(1'b1, 3'b010, BASE + 32'h8, 32'h5555_AAAA);
        @(negedge clk);
        check("rstmid_wen_before", mem_wen, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmid_wen", mem_wen, 32'd0);
        check("rstmid_valid", rsp_valid, 32'd0);
        check("rstmid_req_ready", req_ready, 32'd0);
        @(negedge clk);
        check("rstmid_req_ready_held", req_ready, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_req_ready_after", req_ready, 32'd1);
        check("rstmid_valid_after", rsp_valid, 32'd0);

        load("post_rst", 3'b010, BASE + 32'h8, 32'h0F0F_0F0F, 14'd2, 32'h0F0F_0F0F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
